cp0_exc_unit: RTL and testbench

//   Coprocessor-0 exception/interrupt controller at the M stage of the pipelined MIPS core.

---
 rtl/cp0_exc_unit.sv | 175 +++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// ----------------------------------------------------------------------------
// cp0_exc_unit
//   Coprocessor-0 exception/interrupt controller in the M stage of the
//   pipelined MIPS core. It holds SR, Cause, EPC and PRId. It decides whether
//   the instruction in M takes an exception or an interrupt. It drives the
//   flush/redirect request, and it serves mfc0 reads and mtc0 writes.
//
// Parameters
//   PRID       constant returned when reading PRId (register 15)
//   EXC_ENTRY  handler address presented on exc_pc while req is high
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   M_PC       in   32  PC of the instruction in M
//   M_ExcCode  in   5   pending exception code of the M instruction (0 = none)
//   M_bd       in   1   M instruction sits in a branch delay slot
//   M_eret     in   1   M instruction is eret
//   M_CP0_WE   in   1   M instruction is mtc0
//   CP0_Addr   in   5   CP0 register number for mfc0/mtc0
//   CP0_WD     in   32  mtc0 write data
//   HWInt      in   6   level-sensitive external interrupt lines
//   CP0_RD     out  32  mfc0 read data (combinational, pre-edge value)
//   req        out  1   exception/interrupt taken this cycle
//   exc_pc     out  32  EXC_ENTRY while req, otherwise EPC (eret target)
//   EPC_out    out  32  current EPC value
// ----------------------------------------------------------------------------
module cp0_exc_unit #(
   parameter logic [31:0] PRID      = 32'h2023_0707,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] M_PC,
   input  logic [4:0]  M_ExcCode,
   input  logic        M_bd,
   input  logic        M_eret,
   input  logic        M_CP0_WE,
   input  logic [4:0]  CP0_Addr,
   input  logic [31:0] CP0_WD,
   input  logic [5:0]  HWInt,
   output logic [31:0] CP0_RD,
   output logic        req,
   output logic [31:0] exc_pc,
   output logic [31:0] EPC_out
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // SR.EXL is the state of the exception FSM: NORMAL accepts requests,
   // HANDLER blocks them until eret (or an mtc0 to SR) clears EXL.
   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } exl_state_t;

   exl_state_t  r_state;
   exl_state_t  w_state_nxt;

   logic [5:0]  r_im;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exccode;
   logic [31:2] r_epc;

   logic        w_exl;
   logic        w_int_req;
   logic        w_exc_req;
   logic        w_req;
   logic        w_mtc0;
   logic [31:0] w_epc_src;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic [31:0] w_epc;

   assign w_exl = (r_state == ST_HANDLER);

   // Request generation. The request is held low while rst is asserted, so an
   // exception code that is present during reset is not reported.
   assign w_int_req = (|(HWInt & r_im)) & r_ie & ~w_exl;
   assign w_exc_req = (M_ExcCode != 5'd0) & ~w_exl;
   assign w_req     = (w_int_req | w_exc_req) & ~rst;

   // A taken request or an eret squashes the mtc0 in the same slot.
   assign w_mtc0 = M_CP0_WE & ~w_req & ~M_eret;

   // A delay-slot instruction restarts at its branch (PC - 4, wrapping).
   assign w_epc_src = M_bd ? (M_PC - 32'd4) : M_PC;

   assign w_sr    = {16'd0, r_im, 8'd0, w_exl, r_ie};
   assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
   assign w_epc   = {r_epc, 2'b00};

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state. A request wins over eret, and eret wins over mtc0.
   always_comb begin
      w_state_nxt = r_state;
      if (w_req) begin
         w_state_nxt = ST_HANDLER;
      end else if (M_eret) begin
         w_state_nxt = ST_NORMAL;
      end else if (M_CP0_WE && (CP0_Addr == ADDR_SR)) begin
         w_state_nxt = CP0_WD[1] ? ST_HANDLER : ST_NORMAL;
      end
   end

   // SR fields other than EXL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_im <= 6'd0;
         r_ie <= 1'b0;
      end else if (w_mtc0 && (CP0_Addr == ADDR_SR)) begin
         r_im <= CP0_WD[15:10];
         r_ie <= CP0_WD[0];
      end
   end

   // Cause: IP tracks the interrupt lines every cycle. BD and ExcCode are
   // captured only when a request is taken. An interrupt records code 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ip      <= 6'd0;
         r_bd      <= 1'b0;
         r_exccode <= 5'd0;
      end else begin
         r_ip <= HWInt;
         if (w_req) begin
            r_bd      <= M_bd;
            r_exccode <= w_int_req ? 5'd0 : M_ExcCode;
         end
      end
   end

   // EPC: the restart address is captured on a request, otherwise EPC is
   // written by mtc0. The low two bits are never stored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_epc <= 30'd0;
      end else if (w_req) begin
         r_epc <= w_epc_src[31:2];
      end else if (w_mtc0 && (CP0_Addr == ADDR_EPC)) begin
         r_epc <= CP0_WD[31:2];
      end
   end

   // mfc0 read mux. It returns the current register contents and does not
   // bypass an mtc0 in the same cycle.
   always_comb begin
      CP0_RD = 32'd0;
      case (CP0_Addr)
         ADDR_SR:    CP0_RD = w_sr;
         ADDR_CAUSE: CP0_RD = w_cause;
         ADDR_EPC:   CP0_RD = w_epc;
         ADDR_PRID:  CP0_RD = PRID;
         default:    CP0_RD = 32'd0;
      endcase
   end

   assign req     = w_req;
   assign exc_pc  = w_req ? EXC_ENTRY : w_epc;
   assign EPC_out = w_epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// ----------------------------------------------------------------------------
// tb_cp0_exc_unit
//   Directed self-checking bench for cp0_exc_unit. Inputs change 1 time unit
//   after the rising edge. Outputs are sampled before the next rising edge.
// ----------------------------------------------------------------------------
module tb_cp0_exc_unit;

   localparam logic [31:0] PRID      = 32'h2023_0707;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

   logic        clk;
   logic        rst;
   logic [31:0] M_PC;
   logic [4:0]  M_ExcCode;
   logic        M_bd;
   logic        M_eret;
   logic        M_CP0_WE;
   logic [4:0]  CP0_Addr;
   logic [31:0] CP0_WD;
   logic [5:0]  HWInt;
   logic [31:0] CP0_RD;
   logic        req;
   logic [31:0] exc_pc;
   logic [31:0] EPC_out;

   int n_cmp;
   int n_err;

   cp0_exc_unit #(
      .PRID      (PRID),
      .EXC_ENTRY (EXC_ENTRY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .M_PC      (M_PC),
      .M_ExcCode (M_ExcCode),
      .M_bd      (M_bd),
      .M_eret    (M_eret),
      .M_CP0_WE  (M_CP0_WE),
      .CP0_Addr  (CP0_Addr),
      .CP0_WD    (CP0_WD),
      .HWInt     (HWInt),
      .CP0_RD    (CP0_RD),
      .req       (req),
      .exc_pc    (exc_pc),
      .EPC_out   (EPC_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      CP0_Addr = a;
      #1;
      v = CP0_RD;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] wd);
      CP0_Addr = a;
      CP0_WD   = wd;
      M_CP0_WE = 1'b1;
      step();
      M_CP0_WE = 1'b0;
   endtask

   logic [31:0] v;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      M_PC      = 32'd0;
      M_ExcCode = 5'd5;
      M_bd      = 1'b0;
      M_eret    = 1'b0;
      M_CP0_WE  = 1'b0;
      CP0_Addr  = 5'd0;
      CP0_WD    = 32'd0;
      HWInt     = 6'd0;

      // Power-on reset values
      #2;
      chk("por_req", {31'd0, req}, 32'd0);
      rd(5'd12, v); chk("por_sr", v, 32'd0);
      rd(5'd13, v); chk("por_cause", v, 32'd0);
      rd(5'd15, v); chk("por_prid", v, PRID);
      chk("por_excpc", exc_pc, 32'd0);
      step();
      rst       = 1'b0;
      M_ExcCode = 5'd0;

      // Load SR and EPC, and check there is no same-cycle bypass
      HWInt = 6'b000010;
      mtc0(5'd12, 32'h0000_FC03);
      rd(5'd12, v); chk("sr_write", v, 32'h0000_FC03);
      CP0_Addr = 5'd14;
      CP0_WD   = 32'h1234_5677;
      M_CP0_WE = 1'b1;
      #1;
      chk("no_bypass", CP0_RD, 32'd0);
      step();
      M_CP0_WE = 1'b0;
      chk("epc_write", EPC_out, 32'h1234_5674);
      rd(5'd13, v); chk("cause_ip", v, 32'h0000_0800);

      // Asynchronous reset pulse in the middle of the cycle
      M_ExcCode = 5'd3;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_req", {31'd0, req}, 32'd0);
      rd(5'd12, v); chk("rst_sr", v, 32'd0);
      rd(5'd13, v); chk("rst_cause", v, 32'd0);
      rd(5'd14, v); chk("rst_epc", v, 32'd0);
      rd(5'd15, v); chk("rst_prid", v, PRID);
      chk("rst_excpc", exc_pc, 32'd0);
      step();
      rd(5'd13, v); chk("rst_hold_cause", v, 32'd0);
      rst       = 1'b0;
      M_ExcCode = 5'd0;
      HWInt     = 6'd0;
      step();

      // Interrupt on HWInt[0] with IM[10] and IE set
      mtc0(5'd12, 32'h0000_0401);
      M_PC  = 32'h0000_3000;
      HWInt = 6'b000001;
      #1;
      chk("int_req", {31'd0, req}, 32'd1);
      chk("int_excpc", exc_pc, EXC_ENTRY);
      step();
      HWInt = 6'd0;
      rd(5'd13, v); chk("int_cause", v, 32'h0000_0400);
      rd(5'd12, v); chk("int_sr", v, 32'h0000_0403);
      chk("int_epc", EPC_out, 32'h0000_3000);
      HWInt = 6'b000001;
      #1;
      chk("int_nonest", {31'd0, req}, 32'd0);
      HWInt  = 6'd0;
      M_eret = 1'b1;
      step();
      M_eret = 1'b0;
      rd(5'd12, v); chk("int_eret_sr", v, 32'h0000_0401);

      // Exception in a branch delay slot
      M_PC      = 32'h0000_3008;
      M_bd      = 1'b1;
      M_ExcCode = 5'd12;
      #1;
      chk("bd_req", {31'd0, req}, 32'd1);
      chk("bd_excpc", exc_pc, EXC_ENTRY);
      step();
      M_ExcCode = 5'd0;
      M_bd      = 1'b0;
      chk("bd_epc", EPC_out, 32'h0000_3004);
      rd(5'd13, v); chk("bd_cause", v, 32'h8000_0030);
      chk("bd_excpc_epc", exc_pc, 32'h0000_3004);

      // In the handler, exceptions and interrupts are blocked
      M_ExcCode = 5'd10;
      HWInt     = 6'b000001;
      #1;
      chk("hdl_req", {31'd0, req}, 32'd0);
      step();
      M_ExcCode = 5'd0;
      HWInt     = 6'd0;
      chk("hdl_epc", EPC_out, 32'h0000_3004);
      rd(5'd13, v); chk("hdl_cause", v, 32'h8000_0430);
      rd(5'd12, v); chk("hdl_sr", v, 32'h0000_0403);
      M_eret = 1'b1;
      step();
      M_eret = 1'b0;
      rd(5'd12, v); chk("hdl_eret_sr", v, 32'h0000_0401);

      // mtc0 EPC squashed by an exception in the same cycle
      M_PC      = 32'h0000_5000;
      M_ExcCode = 5'd4;
      CP0_Addr  = 5'd14;
      CP0_WD    = 32'h1234_5677;
      M_CP0_WE  = 1'b1;
      #1;
      chk("sq_req", {31'd0, req}, 32'd1);
      step();
      M_ExcCode = 5'd0;
      M_CP0_WE  = 1'b0;
      chk("sq_epc", EPC_out, 32'h0000_5000);
      rd(5'd13, v); chk("sq_cause", v, 32'h0000_0010);
      rd(5'd12, v); chk("sq_sr", v, 32'h0000_0403);
      M_eret = 1'b1;
      step();

      // Exception together with eret: the request wins and EXL stays set
      M_PC      = 32'h0000_6004;
      M_ExcCode = 5'd8;
      #1;
      chk("ereq_req", {31'd0, req}, 32'd1);
      step();
      M_ExcCode = 5'd0;
      M_eret    = 1'b0;
      rd(5'd12, v); chk("ereq_sr", v, 32'h0000_0403);
      chk("ereq_epc", EPC_out, 32'h0000_6004);
      rd(5'd13, v); chk("ereq_cause", v, 32'h0000_0020);
      M_eret = 1'b1;
      step();
      M_eret = 1'b0;

      // mtc0 EPC without an exception; Cause and unknown addresses are read-only
      mtc0(5'd14, 32'h1234_5677);
      chk("mtc0_epc", EPC_out, 32'h1234_5674);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd(5'd13, v); chk("cause_ro", v, 32'h0000_0020);
      mtc0(5'd7, 32'hFFFF_FFFF);
      rd(5'd7, v); chk("addr7", v, 32'd0);

      // Clearing EXL via mtc0 with an interrupt pending fires on the next cycle
      mtc0(5'd12, 32'h0000_0403);
      HWInt = 6'b000001;
      #1;
      chk("clr_req_blk", {31'd0, req}, 32'd0);
      CP0_Addr = 5'd12;
      CP0_WD   = 32'h0000_0401;
      M_CP0_WE = 1'b1;
      M_PC     = 32'h0000_7000;
      #1;
      chk("clr_req_same", {31'd0, req}, 32'd0);
      step();
      M_CP0_WE = 1'b0;
      chk("clr_req_next", {31'd0, req}, 32'd1);
      step();
      HWInt = 6'd0;
      chk("clr_epc", EPC_out, 32'h0000_7000);
      rd(5'd12, v); chk("clr_sr", v, 32'h0000_0403);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
